// File: rtl/tri_bus_pkg.sv
// Shared types and defaults for the tri-state bus receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tri_bus_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        TURN = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrapping pointers and an occupancy count.
// Latency: push visible at pop_data one cycle later (fall-through from empty).
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  logic [DATA_WIDTH-1:0]                push_data,
    input  logic                                 pop,
    output logic [DATA_WIDTH-1:0]                pop_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
    output logic                                 full,
    output logic                                 empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Head reads as zero when nothing is buffered so reset leaves a clean output.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so pointer wrap is the natural binary rollover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tri_bus_reader.sv
// Captures words from the shared tri-state bus into a FIFO, streams them out ready/valid.
// Latency: captured word appears on out_data one cycle after the capture edge.
// Backpressure: bus_ready drops when full and for one turnaround cycle after each burst; words offered then are dropped and flagged.
module tri_bus_reader
    import tri_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH-1:0]            bus_data,
    input  logic                             bus_valid,
    output logic                             bus_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overflow,
    input  logic                             clear_overflow
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    state_t          state;
    state_t          state_n;
    logic            push;
    logic            pop;
    logic            drop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   cnt_n;

    assign push      = bus_valid && bus_ready && !full;
    assign pop       = out_valid && out_ready;
    assign drop      = bus_valid && !bus_ready;
    assign out_valid = !empty;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus_valid && bus_ready) state_n = RECV;
            RECV:    if (!bus_valid)             state_n = TURN;
            TURN:                                state_n = IDLE;
            default:                             state_n = IDLE;
        endcase
    end

    always_comb begin
        cnt_n = fifo_count;
        if (push && !pop) begin
            cnt_n = fifo_count + 1'b1;
        end else if (pop && !push) begin
            cnt_n = fifo_count - 1'b1;
        end
    end

    // bus_ready is registered from next state and next occupancy, so it is
    // low throughout reset and never depends on the current cycle's pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus_ready <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            bus_ready <= (state_n != TURN) && (cnt_n != CW'(FIFO_DEPTH));
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus_data),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: doc/tri_bus_reader.md
Name: tri_bus_reader

Overview:
Receiving end of the shared tri-state data bus. Remote initiators drive the bus through tri_state_buffer instances.
- Samples the resolved bus net when the active driver signals valid.
- Buffers captured words in a small FIFO and presents them on a ready/valid stream.
- Enforces a one-cycle bus turnaround after each burst so a driver releasing to high-Z is never sampled.

Parameters:
DATA_WIDTH, 8, width of the tri-state data bus and output word
FIFO_DEPTH, 4, words of capture buffering; power of two, >= 2

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
bus_data  input  DATA_WIDTH  resolved tri-state bus net, meaningful only while bus_valid=1
bus_valid  input  1  driver's enable mirror: 1 = bus_data driven and valid this cycle
bus_ready  output  1  reader will capture bus_data this cycle if bus_valid=1
out_data  output  DATA_WIDTH  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  downstream accepts out_data this cycle
fifo_count  output  $clog2(FIFO_DEPTH+1)  words currently buffered
overflow  output  1  sticky: a bus word was presented and dropped
clear_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync-to-clk deassert use): state=IDLE, FIFO empty, fifo_count=0, out_valid=0, out_data=0, overflow=0, bus_ready=0 during reset.
- FSM states: IDLE, RECV, TURN.
  - IDLE: bus_ready = !full. bus_valid&&bus_ready -> capture word, go RECV.
  - RECV: bus_ready = !full. bus_valid&&bus_ready -> capture, stay. bus_valid=0 -> TURN.
  - TURN: bus_ready=0 for exactly one cycle, then IDLE unconditionally.
- full/empty are computed from registered fifo_count only, never from the current cycle's pop.
- Capture: bus_data is written into the FIFO on the clk edge where bus_valid&&bus_ready. Latency to out_valid is 1 cycle (first-word fall-through from an empty FIFO).
- Drop: bus_valid=1 with bus_ready=0 (full, or in TURN) -> word discarded, overflow set next edge. In RECV the FSM stays in RECV while bus_valid stays 1.
- Output: out_valid = (fifo_count != 0); out_data = head word, held stable while out_valid&&!out_ready. Pop on out_valid&&out_ready.
- Simultaneous push+pop: count unchanged, both pointers advance. When full, bus_ready=0, so a pop and a push never occur in the same full cycle; bus_ready rises the cycle after the pop.
- Pointers wrap modulo FIFO_DEPTH. fifo_count saturates structurally at FIFO_DEPTH and never wraps.
- overflow: set has priority over clear_overflow in the same cycle.
- Reset mid-burst: FIFO contents lost, FSM returns to IDLE, bus_ready=0 until reset releases.

Decomposition:
- Package tri_bus_pkg: default DATA_WIDTH, and the state enum typedef (IDLE, RECV, TURN) as logic [1:0].
- One sub-module, sync_fifo (DATA_WIDTH, FIFO_DEPTH): registered storage, wrapping read/write pointers, count, full/empty.
- tri_bus_reader holds the FSM, ready generation, overflow flag and the sync_fifo instance.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with bus_valid=0 -> bus_ready=0, out_valid=0, fifo_count=0, overflow=0. After release, bus_ready=1.
- Single word: bus_valid=1, bus_data=8'hA5 for 1 cycle, out_ready=1 -> out_valid=1, out_data=A5 the next cycle. bus_ready=0 in the following cycle (TURN), then 1 again.
- Burst to full: out_ready=0, 6 consecutive words 01..06 -> 01..04 buffered, fifo_count=4, bus_ready=0 after the 4th word, 05 and 06 dropped, overflow=1. Then drain 01,02,03,04 in order.
- Turnaround violation: burst ends, bus_valid reasserted in the TURN cycle with 8'h3C -> 3C not captured, overflow=1. clear_overflow for 1 cycle -> overflow=0.
- Concurrent push/pop: FIFO holding 2 words, out_ready=1, burst of 4 words -> fifo_count stays 2, output order exactly preserved, no overflow.
- Mid-burst reset: assert rst_n=0 after 2 of 4 words -> out_valid=0 and fifo_count=0 immediately (async). After release, words arrive starting from a fresh IDLE.
